// File: rtl/gesture_cmd_sched.sv
// Round-robin scheduler of roll/pitch/throttle decoder results onto one transmitter byte channel, with frame-timeout neutral failsafe.
// Latency: a decoder valid sampled at edge E0 with the scheduler idle gives tx_valid after edge E1; at most one word per 2 cycles.
// Backpressure: tx_valid/tx_data hold until tx_ready; newer results overwrite pending ones and are counted in drop_count.
module gesture_cmd_sched #(
    parameter int unsigned TIMEOUT_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [3:0] roll_mag,
    input  logic [3:0] pitch_mag,
    input  logic [3:0] thr_mag,
    input  logic [1:0] roll_dir,
    input  logic [1:0] pitch_dir,
    input  logic [1:0] thr_dir,
    input  logic       roll_valid,
    input  logic       pitch_valid,
    input  logic       thr_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       failsafe,
    output logic [7:0] drop_count
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state_q, state_d;
    logic [5:0] hold_q [3];
    logic [2:0] pend_q;
    logic [1:0] rr_ptr;
    logic [7:0] frame_cnt;

    logic [2:0] in_vld;
    logic [5:0] in_val [3];
    logic       any_vld;
    logic [1:0] cand1, cand2, sel;
    logic [2:0] load_en;
    logic [2:0] drop_vec;
    logic [1:0] drop_sum;
    logic [8:0] drop_total;
    logic [7:0] cnt_inc;
    logic       fire;

    assign in_vld    = {thr_valid, pitch_valid, roll_valid};
    assign in_val[0] = {roll_dir, roll_mag};
    assign in_val[1] = {pitch_dir, pitch_mag};
    assign in_val[2] = {thr_dir, thr_mag};
    assign any_vld   = |in_vld;

    // Search order starts just after the last served axis and wraps back to it.
    assign cand1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    assign cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    assign sel   = pend_q[cand1] ? cand1 : (pend_q[cand2] ? cand2 : rr_ptr);

    always_comb begin
        state_d = state_q;
        load_en = 3'b000;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    load_en[sel] = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_valid = (state_q == SEND);

    assign drop_vec   = in_vld & pend_q & ~load_en;
    assign drop_sum   = {1'b0, drop_vec[0]} + {1'b0, drop_vec[1]} + {1'b0, drop_vec[2]};
    assign drop_total = {1'b0, drop_count} + {7'd0, drop_sum};

    // Neutral injection fires once, on the tick that reaches the timeout.
    assign cnt_inc = (frame_cnt == 8'hFF) ? 8'hFF : frame_cnt + 8'd1;
    assign fire    = frame_tick && !any_vld && !failsafe && (cnt_inc == 8'(TIMEOUT_FRAMES));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            pend_q     <= 3'b000;
            rr_ptr     <= 2'd2;
            frame_cnt  <= 8'd0;
            failsafe   <= 1'b0;
            drop_count <= 8'd0;
            tx_data    <= 8'd0;
            for (int i = 0; i < 3; i++) hold_q[i] <= 6'd0;
        end else begin
            state_q <= state_d;
            if (|load_en) begin
                tx_data <= {sel, hold_q[sel]};
                rr_ptr  <= sel;
            end
            for (int i = 0; i < 3; i++) begin
                if (in_vld[i]) begin
                    hold_q[i] <= in_val[i];
                    pend_q[i] <= 1'b1;
                end else if (fire) begin
                    hold_q[i] <= 6'd0;
                    pend_q[i] <= 1'b1;
                end else if (load_en[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
            drop_count <= drop_total[8] ? 8'hFF : drop_total[7:0];
            if (any_vld) begin
                frame_cnt <= 8'd0;
                failsafe  <= 1'b0;
            end else begin
                if (frame_tick) frame_cnt <= cnt_inc;
                if (fire) failsafe <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gesture_cmd_sched.sv
// Directed bench for gesture_cmd_sched: expected words queued at stimulus time, popped on each accepted handshake.
module tb_gesture_cmd_sched;

    localparam int unsigned TO = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [3:0] roll_mag, pitch_mag, thr_mag;
    logic [1:0] roll_dir, pitch_dir, thr_dir;
    logic       roll_valid, pitch_valid, thr_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       failsafe;
    logic [7:0] drop_count;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] exp_q [$];

    gesture_cmd_sched #(.TIMEOUT_FRAMES(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .roll_mag   (roll_mag),
        .pitch_mag  (pitch_mag),
        .thr_mag    (thr_mag),
        .roll_dir   (roll_dir),
        .pitch_dir  (pitch_dir),
        .thr_dir    (thr_dir),
        .roll_valid (roll_valid),
        .pitch_valid(pitch_valid),
        .thr_valid  (thr_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .failsafe   (failsafe),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [5:0] r, input logic [5:0] p, input logic [5:0] t);
        {roll_dir, roll_mag}   = r;
        {pitch_dir, pitch_mag} = p;
        {thr_dir, thr_mag}     = t;
        roll_valid  = v[0];
        pitch_valid = v[1];
        thr_valid   = v[2];
        step();
        roll_valid  = 1'b0;
        pitch_valid = 1'b0;
        thr_valid   = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        nvec++;
        assert (exp_q.size() == 0) else begin
            nerr++;
            $error("FAIL drain_timeout observed=%0d_left expected=0_left", exp_q.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        exp_q.delete();
    endtask

    // Scoreboard: every accepted word must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset && tx_valid && tx_ready) begin
            nvec++;
            assert (exp_q.size() != 0) else begin
                nerr++;
                $error("FAIL unexpected_word observed=%h expected=none", tx_data);
            end
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                assert (tx_data === e) else begin
                    nerr++;
                    $error("FAIL sb_word observed=%h expected=%h", tx_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; frame_tick = 1'b0; tx_ready = 1'b0;
        roll_mag = 0; pitch_mag = 0; thr_mag = 0;
        roll_dir = 0; pitch_dir = 0; thr_dir = 0;
        roll_valid = 0; pitch_valid = 0; thr_valid = 0;
        step();
        step();
        chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_failsafe", {7'd0, failsafe}, 8'h00);
        chk("rst_drop", drop_count, 8'h00);
        reset = 1'b1;

        // Single roll word, latency and one-cycle handshake
        tx_ready = 1'b1;
        exp_q.push_back(8'h1F);
        drive(3'b001, {2'b01, 4'd15}, 6'd0, 6'd0);
        chk("t1_e0_valid", {7'd0, tx_valid}, 8'h00);
        step();
        chk("t1_e1_valid", {7'd0, tx_valid}, 8'h01);
        chk("t1_e1_data", tx_data, 8'h1F);
        step();
        chk("t1_e2_valid", {7'd0, tx_valid}, 8'h00);
        step();
        chk("t1_idle", {7'd0, tx_valid}, 8'h00);
        drain(5);

        // Three axes at once, round-robin from roll, one word per 2 cycles
        do_reset();
        tx_ready = 1'b1;
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h67);
        exp_q.push_back(8'h92);
        drive(3'b111, {2'b01, 4'd5}, {2'b10, 4'd7}, {2'b01, 4'd2});
        step();
        chk("t2_w0_valid", {7'd0, tx_valid}, 8'h01);
        chk("t2_w0_data", tx_data, 8'h15);
        step();
        chk("t2_gap0", {7'd0, tx_valid}, 8'h00);
        step();
        chk("t2_w1_data", tx_data, 8'h67);
        step();
        chk("t2_gap1", {7'd0, tx_valid}, 8'h00);
        step();
        chk("t2_w2_valid", {7'd0, tx_valid}, 8'h01);
        chk("t2_w2_data", tx_data, 8'h92);
        drain(10);
        chk("t2_drop", drop_count, 8'h00);

        // Backpressure hold plus one roll overwrite
        tx_ready = 1'b0;
        exp_q.push_back(8'h53);
        drive(3'b010, 6'd0, {2'b01, 4'd3}, 6'd0);
        step();
        drive(3'b001, {2'b01, 4'd7}, 6'd0, 6'd0);
        drive(3'b001, {2'b01, 4'd2}, 6'd0, 6'd0);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_data", tx_data, 8'h53);
            step();
        end
        chk("t3_hold_valid", {7'd0, tx_valid}, 8'h01);
        chk("t3_drop", drop_count, 8'h01);
        exp_q.push_back(8'h12);
        tx_ready = 1'b1;
        drain(20);
        chk("t3_drop_after", drop_count, 8'h01);

        // Frame timeout failsafe
        do_reset();
        tx_ready = 1'b1;
        tick();
        tick();
        chk("t4_pre_failsafe", {7'd0, failsafe}, 8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h80);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("t4_failsafe_set", {7'd0, failsafe}, 8'h01);
        drain(20);
        tick();
        tick();
        tick();
        chk("t4_no_reinject", {7'd0, tx_valid}, 8'h00);
        chk("t4_failsafe_hold", {7'd0, failsafe}, 8'h01);
        chk("t4_drop", drop_count, 8'h00);
        exp_q.push_back(8'h51);
        drive(3'b010, 6'd0, {2'b01, 4'd1}, 6'd0);
        chk("t4_failsafe_clr", {7'd0, failsafe}, 8'h00);
        drain(10);

        // Load/capture collision keeps new value pending without a drop
        do_reset();
        tx_ready = 1'b1;
        exp_q.push_back(8'h13);
        exp_q.push_back(8'h14);
        drive(3'b001, {2'b01, 4'd3}, 6'd0, 6'd0);
        drive(3'b001, {2'b01, 4'd4}, 6'd0, 6'd0);
        chk("t5_first_data", tx_data, 8'h13);
        drain(10);
        chk("t5_drop", drop_count, 8'h00);

        // Multi-axis drops and saturation
        do_reset();
        tx_ready = 1'b0;
        drive(3'b001, {2'b01, 4'd1}, 6'd0, 6'd0);
        step();
        drive(3'b111, {2'b10, 4'd9}, {2'b10, 4'd4}, {2'b11, 4'd6});
        drive(3'b111, {2'b10, 4'd9}, {2'b10, 4'd4}, {2'b11, 4'd6});
        chk("t6_drop3", drop_count, 8'h03);
        roll_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        roll_valid = 1'b0;
        step();
        chk("t6_drop_sat", drop_count, 8'hFF);
        chk("t6_held_data", tx_data, 8'h11);

        // Reset during SEND discards in-flight and pending words
        reset = 1'b0;
        step();
        chk("t7_rst_valid", {7'd0, tx_valid}, 8'h00);
        chk("t7_rst_data", tx_data, 8'h00);
        chk("t7_rst_drop", drop_count, 8'h00);
        reset = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t7_no_resume", {7'd0, tx_valid}, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gesture_cmd_sched.md
# gesture_cmd_sched

Command scheduler between the gesture-decode units (roll, pitch, throttle) and the drone radio transmitter. Each decoder produces a magnitude/direction result with a one-cycle valid pulse; this block holds the latest result per axis, shares the single transmitter byte channel among the three axes round-robin over a valid/ready handshake, and injects neutral commands when no gesture update has arrived for a configurable number of video frames. It sits after Roll/Pitch/Throttle and before the transmitter serializer.

## Interface
- TIMEOUT_FRAMES, 30, frame_tick count with no decoder valid before failsafe (1..255)
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- roll_mag / pitch_mag / thr_mag  in  4 each  decoder magnitudes
- roll_dir / pitch_dir / thr_dir  in  2 each  decoder directions (2'b00 = neutral)
- roll_valid / pitch_valid / thr_valid  in  1 each  one-cycle result pulses
- tx_data  out  8  command word {axis[1:0], dir[1:0], mag[3:0]}; axis 00 roll, 01 pitch, 10 throttle
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts word
- failsafe  out  1  timeout state active
- drop_count  out  8  saturating count of overwritten un-sent results

## Operation
- Per axis: holding register {dir, mag} plus pending flag. On x_valid, register loads inputs, pending set.
- Overwrite: x_valid while axis already pending and not loaded that cycle -> value replaced, drop_count += 1. Several axes dropping same cycle -> add count of drops; saturate at 255.
- FSM states IDLE, SEND.
  - IDLE: if any pending, select next pending axis after rr_ptr in order roll -> pitch -> throttle -> roll; load tx_data, clear that pending, rr_ptr <= selected, go SEND. Otherwise stay.
  - SEND: tx_valid = 1, tx_data frozen. tx_valid & tx_ready at edge -> IDLE. No timeout; waits indefinitely.
- Load/capture collision: x_valid on same cycle that axis is loaded -> tx_data gets old value, pending stays set with new value, not a drop.
- Failsafe: frame counter (8-bit, saturating) clears on any x_valid, increments on frame_tick otherwise. frame_tick making counter equal TIMEOUT_FRAMES while failsafe = 0 -> failsafe <= 1 and all three axes loaded with {00, 0000}, pending set (one neutral word per axis, single injection). These injections never count as drops. Axis with x_valid same cycle takes decoder value instead.
- failsafe clears on any x_valid (same edge). Counter restarts from 0.
- x_valid and frame_tick same cycle -> valid wins, counter = 0.

## Timing
- Reset (reset = 0 at edge): tx_valid 0, tx_data 0, failsafe 0, drop_count 0, all pending 0, holding regs 0, frame counter 0, rr_ptr = throttle (roll served first), FSM IDLE. Reset mid-SEND drops the word in flight.
- Latency: x_valid sampled at edge E0 with FSM IDLE and nothing else pending -> tx_valid high after edge E1.
- Handshake accepted at edge Eh -> tx_valid low Eh..Eh+1; next word tx_valid high after Eh+1 earliest. Max throughput one word per 2 cycles with tx_ready held high.
- tx_data must not change while tx_valid = 1 and tx_ready = 0.
- Failsafe: neutral words start after the timeout frame_tick edge + 1, order per rr_ptr.

## Test plan
- Reset then roll_valid with mag 15, dir 01, tx_ready = 1 -> tx_valid after next edge, tx_data = 8'h1F, one cycle, then idle.
- roll, pitch, thr valid same cycle (mags 5, 7, 2, dirs 01, 10, 01), tx_ready = 1 -> words 8'h15, 8'h67, 8'h92 in order, 2 cycles apart, drop_count 0.
- tx_ready low 10 cycles during SEND, roll_valid twice (mag 7 then 2) -> tx_data held; after ready, next roll word mag 2, drop_count = 1.
- TIMEOUT_FRAMES = 3, no valids, 3 frame_ticks -> failsafe = 1, words 8'h00, 8'h40, 8'h80; further ticks inject nothing; then pitch_valid -> failsafe 0 same edge.
- drop_count saturation: 300 overwrites with tx_ready low -> drop_count = 255.
- reset low during SEND with tx_ready low -> tx_valid 0 next edge, no pending words resume after reset release.
